gfx_floodfill_mem_responder: RTL and testbench
==============================================

Name: gfx_floodfill_mem_responder

Overview:
Services the flood-fill engine's memory traffic as the responder end of its pixel-fetch interface. It answers line-read requests (read_request/adr, then ack/data) and performs pixel read-modify-write stores. It holds a single-line cache so repeated fetches of neighbouring pixels in the same memory line do not go back to memory. It sits between the flood-fill engine and the memory arbiter as a bus master.

Parameters:
MDW, 256, memory data width in bits; the line size is MDW/8 bytes.
MBW, 8, width of the bit-offset field; MBW = log2(MDW).

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
read_request_i  in  1  engine line-read request; level, held until ack
adr_i  in  32  read byte address; low log2(MDW/8) bits ignored
ack_o  out  1  one-cycle pulse; data_o is valid in the same cycle
data_o  out  MDW  returned memory line
wr_req_i  in  1  pixel write request; level, held until wr_ack_o
wr_adr_i  in  32  write byte address; line aligned internally
wr_mb_i  in  MBW  pixel bit offset within the line
wr_color_i  in  32  pixel colour; low bpp_i bits are used
bpp_i  in  6  bits per pixel, 1..32
wr_ack_o  out  1  one-cycle pulse when the write has completed in memory
m_cyc_o  out  1  bus cycle
m_stb_o  out  1  bus strobe
m_we_o  out  1  bus write enable
m_adr_o  out  32  line-aligned bus address
m_sel_o  out  MDW/8  byte selects; always all ones
m_dat_o  out  MDW  bus write data
m_ack_i  in  1  bus acknowledge
m_dat_i  in  MDW  bus read data
hit_o  out  1  one-cycle pulse on a cache-hit read, for statistics

Behaviour:
- Reset (rst_i=1, synchronous):
  - all outputs 0; cache valid bit cleared; state IDLE.
  - Reset mid-operation drops m_cyc_o/m_stb_o in the next cycle; no ack of any kind is issued.
- Line address la = {adr[31:log2(MDW/8)], zeros}.
- Cache: one line register, one tag (la), one valid bit.
- States:
  - IDLE, RD_MEM, WR_FETCH, WR_MERGE, WR_MEM.
  - DONE is a one-cycle ack state that returns to IDLE.
- IDLE:
  - wr_req_i has priority over read_request_i when both are high.
  - Read hit (valid and tag==la): ack_o=1, data_o=cache, hit_o=1 in the next cycle. Latency 1 cycle from the request being sampled.
  - Read miss: go to RD_MEM; drive m_cyc_o=m_stb_o=1, m_we_o=0, m_adr_o=la.
  - Write: hit goes to WR_MERGE; miss goes to WR_FETCH (a bus read of la, same as RD_MEM).
- RD_MEM:
  - On m_ack_i: drop cyc/stb; load the cache line and tag, set valid.
  - Next cycle: ack_o=1, data_o=line, then IDLE.
  - A miss therefore costs bus latency + 1 cycle.
- WR_FETCH: on m_ack_i, fill the cache as in RD_MEM, then go to WR_MERGE.
- WR_MERGE (1 cycle):
  - Replace bits [wr_mb_i+bpp_i-1 : wr_mb_i] of the cache line with wr_color_i[bpp_i-1:0]; all other bits unchanged.
  - If wr_mb_i+bpp_i > MDW, only bits below MDW are written; there is no wrap into bit 0.
  - The merged line updates the cache (write-through).
- WR_MEM:
  - Drive m_cyc_o=m_stb_o=m_we_o=1, m_adr_o=tag, m_dat_o=merged line.
  - On m_ack_i: drop the bus signals; wr_ack_o=1 in the next cycle; then IDLE.
- Ack pulses:
  - ack_o and wr_ack_o are exactly one cycle wide.
  - The requester deasserts its request in the cycle it sees ack. In the cycle after a DONE the block is in IDLE, and a request still high there is treated as a new request.
- Bus signals: m_adr_o, m_we_o and m_dat_o stay stable while m_stb_o=1. m_ack_i outside RD_MEM/WR_FETCH/WR_MEM is ignored.
- bpp_i=0 is treated as 1. bpp_i>32 is clamped to 32.
- Coherency: the cache is the only writer's copy; external memory writes are not snooped.
- No request is lost: a request arriving while busy is serviced when the block returns to IDLE, because requests are level-held.

Test Plan:
- Read miss: reset, read_request_i=1, adr_i=0x1000_0024, memory returns 0xA5.. after 3 cycles -> m_adr_o=0x1000_0020, then ack_o pulses 1 cycle with data_o=0xA5..; hit_o=0.
- Read hit: after the miss above, read adr_i=0x1000_003C -> ack_o 1 cycle after the request, hit_o=1, no m_cyc_o activity.
- Pixel write on a hit: cached line all zeros, wr_mb_i=16, bpp_i=8, wr_color_i=0x12345678 -> bus write of a line with bits[23:16]=0x78 and all other bits 0; wr_ack_o pulses 1 cycle after m_ack_i; a subsequent read hit returns the merged line.
- Pixel write on a miss: wr_adr_i in a new line -> bus read, then bus write to the same la; cache tag updated; m_sel_o all ones throughout.
- Simultaneous requests: read_request_i and wr_req_i both raised in the same cycle -> the write completes first (wr_ack_o), then ack_o for the read; edge case wr_mb_i=248, bpp_i=16 writes bits[255:248] only.
- Reset mid-operation: assert rst_i while m_stb_o=1 in RD_MEM -> next cycle all outputs 0, valid cleared; a following read of the same address misses.

Source files
------------

// File: rtl/gfx_floodfill_mem_responder.sv
// Memory responder for the flood-fill engine: line reads through a one-line cache
// and pixel read-modify-write stores written through to the bus.
module gfx_floodfill_mem_responder #(
   parameter int MDW = 256,
   parameter int MBW = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             read_request_i,
   input  logic [31:0]      adr_i,
   output logic             ack_o,
   output logic [MDW-1:0]   data_o,
   input  logic             wr_req_i,
   input  logic [31:0]      wr_adr_i,
   input  logic [MBW-1:0]   wr_mb_i,
   input  logic [31:0]      wr_color_i,
   input  logic [5:0]       bpp_i,
   output logic             wr_ack_o,
   output logic             m_cyc_o,
   output logic             m_stb_o,
   output logic             m_we_o,
   output logic [31:0]      m_adr_o,
   output logic [MDW/8-1:0] m_sel_o,
   output logic [MDW-1:0]   m_dat_o,
   input  logic             m_ack_i,
   input  logic [MDW-1:0]   m_dat_i,
   output logic             hit_o
);

   localparam int LB = $clog2(MDW/8);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] RD_MEM   = 3'd1;
   localparam logic [2:0] WR_FETCH = 3'd2;
   localparam logic [2:0] WR_MERGE = 3'd3;
   localparam logic [2:0] WR_MEM   = 3'd4;
   localparam logic [2:0] DONE     = 3'd5;

   logic [2:0]     state_reg;
   logic [MDW-1:0] line_reg;
   logic [31:0]    tag_reg;
   logic           valid_reg;
   logic [MBW-1:0] mb_reg;
   logic [31:0]    color_reg;
   logic [5:0]     bpp_reg;
   logic           ack_reg;
   logic           wr_ack_reg;
   logic           hit_reg;
   logic           cyc_reg;
   logic           we_reg;
   logic [31:0]    adr_reg;
   logic [MDW-1:0] mdat_reg;
   logic [MDW-1:0] data_reg;

   logic [31:0]    rd_la;
   logic [31:0]    wr_la;
   logic           rd_hit;
   logic           wr_hit;
   logic [5:0]     bpp_eff;
   logic [32:0]    pix_mask;
   logic [MDW-1:0] wide_mask;
   logic [MDW-1:0] wide_color;
   logic [MDW-1:0] merged_line;
   logic           unused_bits;

   assign rd_la  = {adr_i[31:LB], {LB{1'b0}}};
   assign wr_la  = {wr_adr_i[31:LB], {LB{1'b0}}};
   assign rd_hit = valid_reg && (tag_reg == rd_la);
   assign wr_hit = valid_reg && (tag_reg == wr_la);

   always_comb begin
      bpp_eff = bpp_reg;
      if (bpp_reg == 6'd0)
         bpp_eff = 6'd1;
      else if (bpp_reg > 6'd32)
         bpp_eff = 6'd32;
   end

   // Mask and colour are shifted in line width, so bits pushed past MDW fall off instead of wrapping.
   assign pix_mask   = (33'd1 << bpp_eff) - 33'd1;
   assign wide_mask  = {{(MDW-32){1'b0}}, pix_mask[31:0]} << mb_reg;
   assign wide_color = {{(MDW-32){1'b0}}, color_reg & pix_mask[31:0]} << mb_reg;

   generate
      for (genvar gi = 0; gi < MDW; gi++) begin : g_merge
         assign merged_line[gi] = wide_mask[gi] ? wide_color[gi] : line_reg[gi];
      end
   endgenerate

   assign unused_bits = ^{adr_i[LB-1:0], wr_adr_i[LB-1:0], pix_mask[32]};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg  <= IDLE;
         line_reg   <= '0;
         tag_reg    <= '0;
         valid_reg  <= 1'b0;
         mb_reg     <= '0;
         color_reg  <= '0;
         bpp_reg    <= '0;
         ack_reg    <= 1'b0;
         wr_ack_reg <= 1'b0;
         hit_reg    <= 1'b0;
         cyc_reg    <= 1'b0;
         we_reg     <= 1'b0;
         adr_reg    <= '0;
         mdat_reg   <= '0;
         data_reg   <= '0;
      end else begin
         ack_reg    <= 1'b0;
         wr_ack_reg <= 1'b0;
         hit_reg    <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (wr_req_i) begin
                  mb_reg    <= wr_mb_i;
                  color_reg <= wr_color_i;
                  bpp_reg   <= bpp_i;
                  if (wr_hit) begin
                     state_reg <= WR_MERGE;
                  end else begin
                     state_reg <= WR_FETCH;
                     cyc_reg   <= 1'b1;
                     we_reg    <= 1'b0;
                     adr_reg   <= wr_la;
                  end
               end else if (read_request_i) begin
                  if (rd_hit) begin
                     ack_reg   <= 1'b1;
                     hit_reg   <= 1'b1;
                     data_reg  <= line_reg;
                     state_reg <= DONE;
                  end else begin
                     state_reg <= RD_MEM;
                     cyc_reg   <= 1'b1;
                     we_reg    <= 1'b0;
                     adr_reg   <= rd_la;
                  end
               end
            end
            RD_MEM: begin
               if (m_ack_i) begin
                  cyc_reg   <= 1'b0;
                  line_reg  <= m_dat_i;
                  tag_reg   <= adr_reg;
                  valid_reg <= 1'b1;
                  ack_reg   <= 1'b1;
                  data_reg  <= m_dat_i;
                  state_reg <= DONE;
               end
            end
            WR_FETCH: begin
               if (m_ack_i) begin
                  cyc_reg   <= 1'b0;
                  line_reg  <= m_dat_i;
                  tag_reg   <= adr_reg;
                  valid_reg <= 1'b1;
                  state_reg <= WR_MERGE;
               end
            end
            WR_MERGE: begin
               line_reg  <= merged_line;
               mdat_reg  <= merged_line;
               cyc_reg   <= 1'b1;
               we_reg    <= 1'b1;
               adr_reg   <= tag_reg;
               state_reg <= WR_MEM;
            end
            WR_MEM: begin
               if (m_ack_i) begin
                  cyc_reg    <= 1'b0;
                  we_reg     <= 1'b0;
                  wr_ack_reg <= 1'b1;
                  state_reg  <= DONE;
               end
            end
            DONE:    state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign ack_o    = ack_reg;
   assign data_o   = data_reg;
   assign wr_ack_o = wr_ack_reg;
   assign hit_o    = hit_reg;
   assign m_cyc_o  = cyc_reg;
   assign m_stb_o  = cyc_reg;
   assign m_we_o   = we_reg;
   assign m_adr_o  = adr_reg;
   assign m_sel_o  = '1;
   assign m_dat_o  = mdat_reg;

endmodule

// File: tb/tb_gfx_floodfill_mem_responder.sv
// Scoreboard bench: stimulus queues expected read/write/bus results, a monitor and
// a bus memory model pop and compare them as the responder produces them.
module tb_gfx_floodfill_mem_responder;

   localparam int MDW = 256;
   localparam int MBW = 8;
   localparam int LAT = 3;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             read_request_i;
   logic [31:0]      adr_i;
   logic             ack_o;
   logic [MDW-1:0]   data_o;
   logic             wr_req_i;
   logic [31:0]      wr_adr_i;
   logic [MBW-1:0]   wr_mb_i;
   logic [31:0]      wr_color_i;
   logic [5:0]       bpp_i;
   logic             wr_ack_o;
   logic             m_cyc_o;
   logic             m_stb_o;
   logic             m_we_o;
   logic [31:0]      m_adr_o;
   logic [MDW/8-1:0] m_sel_o;
   logic [MDW-1:0]   m_dat_o;
   logic             m_ack_i;
   logic [MDW-1:0]   m_dat_i;
   logic             hit_o;

   gfx_floodfill_mem_responder #(.MDW(MDW), .MBW(MBW)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .read_request_i(read_request_i), .adr_i(adr_i),
      .ack_o(ack_o), .data_o(data_o),
      .wr_req_i(wr_req_i), .wr_adr_i(wr_adr_i), .wr_mb_i(wr_mb_i),
      .wr_color_i(wr_color_i), .bpp_i(bpp_i), .wr_ack_o(wr_ack_o),
      .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
      .m_adr_o(m_adr_o), .m_sel_o(m_sel_o), .m_dat_o(m_dat_o),
      .m_ack_i(m_ack_i), .m_dat_i(m_dat_i), .hit_o(hit_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct { logic we; logic [31:0] adr; logic [MDW-1:0] dat; } bus_t;
   typedef struct { logic [MDW-1:0] dat; logic hit; } rd_t;

   bus_t bus_q[$];
   rd_t  rd_q[$];
   int   wr_q[$];
   logic [MDW-1:0] mem [logic [31:0]];
   int   checks = 0;
   int   errors = 0;
   logic ack_at_edge = 1'b0;

   task automatic chk(input string name, input logic [MDW-1:0] act, input logic [MDW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(posedge clk_i) ack_at_edge = m_ack_i;

   // bus memory model: acks LAT negedges after strobe appears and checks the request
   initial begin
      int   cnt;
      bus_t be;
      m_ack_i = 1'b0;
      m_dat_i = '0;
      cnt = 0;
      forever begin
         @(negedge clk_i);
         if (m_ack_i) begin
            m_ack_i = 1'b0;
            cnt = 0;
         end else if (m_stb_o) begin
            cnt++;
            if (cnt == LAT) begin
               if (bus_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL bus_unexpected: got we=%0b adr=%h expected no bus cycle", m_we_o, m_adr_o);
               end else begin
                  be = bus_q.pop_front();
                  chk("bus_we", m_we_o, be.we);
                  chk("bus_adr", m_adr_o, be.adr);
                  if (be.we) chk("bus_wdat", m_dat_o, be.dat);
               end
               if (m_we_o) mem[m_adr_o] = m_dat_o;
               else m_dat_i = mem.exists(m_adr_o) ? mem[m_adr_o] : '0;
               m_ack_i = 1'b1;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // response monitor
   initial begin
      rd_t r;
      logic prev_ack, prev_wack, prev_stb, prev_we;
      logic [31:0] prev_adr;
      logic [MDW-1:0] prev_dat;
      prev_ack = 0; prev_wack = 0; prev_stb = 0; prev_we = 0; prev_adr = '0; prev_dat = '0;
      forever begin
         @(negedge clk_i);
         if (ack_o) begin
            if (rd_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL ack_unexpected: got ack_o=1 expected none");
            end else begin
               r = rd_q.pop_front();
               chk("rd_data", data_o, r.dat);
               chk("rd_hit", hit_o, r.hit);
            end
            if (prev_ack) chk("ack_width", 2, 1);
         end
         if (wr_ack_o) begin
            if (wr_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL wr_ack_unexpected: got wr_ack_o=1 expected none");
            end else begin
               void'(wr_q.pop_front());
               chk("wr_ack_after_m_ack", ack_at_edge, 1'b1);
            end
            if (prev_wack) chk("wr_ack_width", 2, 1);
         end
         if (hit_o && !ack_o) chk("hit_without_ack", ack_o, 1'b1);
         if (m_cyc_o) chk("m_sel", m_sel_o, {(MDW/8){1'b1}});
         if (m_stb_o && prev_stb) begin
            chk("stb_adr_stable", m_adr_o, prev_adr);
            chk("stb_we_stable", m_we_o, prev_we);
            chk("stb_dat_stable", m_dat_o, prev_dat);
         end
         prev_ack = ack_o; prev_wack = wr_ack_o; prev_stb = m_stb_o;
         prev_we = m_we_o; prev_adr = m_adr_o; prev_dat = m_dat_o;
      end
   end

   task automatic do_read(input logic [31:0] adr, input logic [MDW-1:0] exp, input logic exp_hit,
                          input int exp_lat, input string name);
      rd_t  r;
      bus_t b;
      int   n;
      bit   seen, bus_act;
      r.dat = exp; r.hit = exp_hit; rd_q.push_back(r);
      if (!exp_hit) begin
         b.we = 1'b0; b.adr = adr & 32'hFFFF_FFE0; b.dat = '0; bus_q.push_back(b);
      end
      @(negedge clk_i);
      adr_i = adr; read_request_i = 1'b1;
      n = 0; seen = 0; bus_act = 0;
      while (!seen && n < 100) begin
         @(negedge clk_i);
         n++;
         if (m_cyc_o) bus_act = 1;
         if (ack_o) seen = 1;
      end
      read_request_i = 1'b0;
      if (!seen) begin
         checks++; errors++;
         $display("FAIL %s_timeout: got no ack_o expected ack within 100 cycles", name);
      end else begin
         chk_int({name, "_latency"}, n, exp_lat);
         if (exp_hit) chk({name, "_no_bus"}, bus_act, 1'b0);
      end
      $display("read %s adr=%h hit=%0b cycles=%0d", name, adr, exp_hit, n);
   endtask

   task automatic do_write(input logic [31:0] wadr, input logic [7:0] mb, input logic [5:0] bpp,
                           input logic [31:0] color, input logic [MDW-1:0] exp_line,
                           input bit fetch, input int exp_lat, input string name);
      bus_t b;
      int   n;
      bit   seen;
      if (fetch) begin
         b.we = 1'b0; b.adr = wadr & 32'hFFFF_FFE0; b.dat = '0; bus_q.push_back(b);
      end
      b.we = 1'b1; b.adr = wadr & 32'hFFFF_FFE0; b.dat = exp_line; bus_q.push_back(b);
      wr_q.push_back(1);
      @(negedge clk_i);
      wr_adr_i = wadr; wr_mb_i = mb; bpp_i = bpp; wr_color_i = color; wr_req_i = 1'b1;
      n = 0; seen = 0;
      while (!seen && n < 100) begin
         @(negedge clk_i);
         n++;
         if (wr_ack_o) seen = 1;
      end
      wr_req_i = 1'b0;
      if (!seen) begin
         checks++; errors++;
         $display("FAIL %s_timeout: got no wr_ack_o expected wr_ack within 100 cycles", name);
      end else begin
         chk_int({name, "_latency"}, n, exp_lat);
      end
      $display("write %s adr=%h mb=%0d bpp=%0d cycles=%0d", name, wadr, mb, bpp, n);
   endtask

   task automatic chk_outputs_zero(input string name);
      chk({name, "_ack"}, ack_o, 1'b0);
      chk({name, "_wr_ack"}, wr_ack_o, 1'b0);
      chk({name, "_hit"}, hit_o, 1'b0);
      chk({name, "_cyc"}, m_cyc_o, 1'b0);
      chk({name, "_stb"}, m_stb_o, 1'b0);
      chk({name, "_we"}, m_we_o, 1'b0);
      chk({name, "_adr"}, m_adr_o, '0);
      chk({name, "_mdat"}, m_dat_o, '0);
      chk({name, "_data"}, data_o, '0);
   endtask

   initial begin
      logic [MDW-1:0] l1, e2, e3, e4, e5, pat;
      bus_t b;
      rd_t  r;
      int   n;
      bit   saw_w, saw_r;

      rst_i = 1'b1; read_request_i = 0; adr_i = '0; wr_req_i = 0; wr_adr_i = '0;
      wr_mb_i = '0; wr_color_i = '0; bpp_i = '0;

      l1 = {32{8'hA5}};
      mem[32'h1000_0020] = l1;
      mem[32'h2000_0000] = '0;
      pat = {8{32'hDEADBEEF}};
      mem[32'h3000_0040] = pat;
      mem[32'h4000_0000] = {32{8'h11}};

      e2 = '0;  e2[23:16] = 8'h78;
      e3 = pat; e3[0] = 1'b0;
      e4 = e3;  e4[63:32] = 32'hFFFF_FFFF;
      e5 = {32{8'h11}}; e5[255:248] = 8'hCD;

      repeat (3) @(negedge clk_i);
      chk_outputs_zero("reset");
      $display("reset state checked");
      rst_i = 1'b0;

      do_read(32'h1000_0024, l1, 1'b0, 4, "miss_a5");
      do_read(32'h1000_003C, l1, 1'b1, 1, "hit_a5");

      do_read(32'h2000_0000, '0, 1'b0, 4, "miss_zero");
      do_write(32'h2000_0010, 8'd16, 6'd8, 32'h1234_5678, e2, 1'b0, 5, "wr_hit");
      do_read(32'h2000_0004, e2, 1'b1, 1, "hit_after_wr");

      do_write(32'h3000_0044, 8'd0, 6'd0, 32'h0, e3, 1'b1, 8, "wr_miss_bpp0");
      do_read(32'h3000_0050, e3, 1'b1, 1, "hit_new_tag");
      do_write(32'h3000_0040, 8'd32, 6'd40, 32'hFFFF_FFFF, e4, 1'b0, 5, "wr_clamp40");
      do_read(32'h3000_005C, e4, 1'b1, 1, "hit_clamp");

      // simultaneous write and read of the same line: write first, read then hits
      b.we = 1'b0; b.adr = 32'h4000_0000; b.dat = '0; bus_q.push_back(b);
      b.we = 1'b1; b.dat = e5; bus_q.push_back(b);
      wr_q.push_back(1);
      r.dat = e5; r.hit = 1'b1; rd_q.push_back(r);
      @(negedge clk_i);
      adr_i = 32'h4000_0008; read_request_i = 1'b1;
      wr_adr_i = 32'h4000_0000; wr_mb_i = 8'd248; bpp_i = 6'd16; wr_color_i = 32'h0000_ABCD; wr_req_i = 1'b1;
      n = 0; saw_w = 0; saw_r = 0;
      while (!saw_r && n < 200) begin
         @(negedge clk_i);
         n++;
         if (wr_ack_o) begin saw_w = 1; wr_req_i = 1'b0; end
         if (ack_o) begin
            chk("simul_order_wr_first", saw_w, 1'b1);
            saw_r = 1; read_request_i = 1'b0;
         end
      end
      read_request_i = 1'b0; wr_req_i = 1'b0;
      if (!saw_r) begin
         checks++; errors++;
         $display("FAIL simul_timeout: got no ack_o expected ack within 200 cycles");
      end
      $display("simultaneous wr+rd adr=%h cycles=%0d", 32'h4000_0000, n);

      // reset while a read miss is on the bus
      @(negedge clk_i);
      adr_i = 32'h5000_0000; read_request_i = 1'b1;
      n = 0;
      while (!m_stb_o && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      chk("rst_mid_stb_seen", m_stb_o, 1'b1);
      rst_i = 1'b1; read_request_i = 1'b0;
      @(negedge clk_i);
      chk_outputs_zero("rst_mid");
      rst_i = 1'b0;
      $display("reset mid-operation checked");
      do_read(32'h4000_0000, e5, 1'b0, 4, "post_rst_miss");

      repeat (5) @(negedge clk_i);
      chk_int("rd_q_empty", rd_q.size(), 0);
      chk_int("wr_q_empty", wr_q.size(), 0);
      chk_int("bus_q_empty", bus_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish within 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
